// File: rtl/labeled_elastic_pipe.sv
// Elastic pipeline that carries a security label with each data word.
// Supports valid/ready backpressure, bubble collapsing and a label-based scrub that purges entries.
module labeled_elastic_pipe #(
  parameter int            DEPTH = 2,
  parameter int            DW    = 8,
  parameter int            LW    = 2,
  parameter logic [LW-1:0] FLOOR = '0,
  parameter int            CW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LW-1:0]                in_lbl,
  input  logic [DW-1:0]                in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LW-1:0]                out_lbl,
  output logic [DW-1:0]                out_data,
  input  logic                         scrub,
  input  logic [LW-1:0]                scrub_lbl,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CW-1:0]                drop_cnt
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int SW = CW + OW;

  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] offend;
  logic [DEPTH-1:0] src_v;
  logic [LW-1:0]    lbl_reg  [DEPTH];
  logic [LW-1:0]    lbl_next [DEPTH];
  logic [LW-1:0]    src_lbl  [DEPTH];
  logic [DW-1:0]    data_reg  [DEPTH];
  logic [DW-1:0]    data_next [DEPTH];
  logic [DW-1:0]    src_data  [DEPTH];
  logic [CW-1:0]    drop_reg;
  logic [CW-1:0]    drop_next;
  logic [OW-1:0]    n_drop;
  logic [OW-1:0]    occ;
  logic [SW-1:0]    drop_sum;

  // A stage may advance if the one ahead advances or if it is itself empty.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~v_reg[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] | ~v_reg[i];
    end
  end

  // Load sources are zeroed when invalid so empty stages never hold residue.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    assign offend[gi] = v_reg[gi] & (|(lbl_reg[gi] & ~scrub_lbl));
    if (gi == 0) begin : g_head
      assign src_v[gi]    = in_valid;
      assign src_lbl[gi]  = in_valid ? (in_lbl | FLOOR) : '0;
      assign src_data[gi] = in_valid ? in_data : '0;
    end else begin : g_body
      assign src_v[gi]    = v_reg[gi-1];
      assign src_lbl[gi]  = v_reg[gi-1] ? lbl_reg[gi-1] : '0;
      assign src_data[gi] = v_reg[gi-1] ? data_reg[gi-1] : '0;
    end
  end

  always_comb begin
    v_next = v_reg;
    for (int i = 0; i < DEPTH; i++) begin
      lbl_next[i]  = lbl_reg[i];
      data_next[i] = data_reg[i];
      if (scrub) begin
        if (offend[i]) begin
          v_next[i]    = 1'b0;
          lbl_next[i]  = '0;
          data_next[i] = '0;
        end
      end else if (adv[i]) begin
        v_next[i]    = src_v[i];
        lbl_next[i]  = src_lbl[i];
        data_next[i] = src_data[i];
      end
    end
  end

  always_comb begin
    n_drop = '0;
    occ    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_drop = n_drop + OW'(offend[i]);
      occ    = occ + OW'(v_reg[i]);
    end
  end

  // Sum is computed wide so a large scrub cannot wrap before saturating.
  assign drop_sum = SW'(drop_reg) + SW'(n_drop);

  always_comb begin
    drop_next = drop_reg;
    if (scrub) begin
      if (drop_sum > SW'({CW{1'b1}})) begin
        drop_next = {CW{1'b1}};
      end else begin
        drop_next = drop_sum[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg    <= '0;
      drop_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        lbl_reg[i]  <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      v_reg    <= v_next;
      drop_reg <= drop_next;
      for (int i = 0; i < DEPTH; i++) begin
        lbl_reg[i]  <= lbl_next[i];
        data_reg[i] <= data_next[i];
      end
    end
  end

  assign in_ready  = adv[0] & ~scrub;
  assign out_valid = v_reg[DEPTH-1] & ~scrub;
  assign out_lbl   = lbl_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];
  assign occupancy = occ;
  assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_labeled_elastic_pipe.sv
// Directed bench for labeled_elastic_pipe: default instance plus one with FLOOR=2'b10 and CW=2.
module tb_labeled_elastic_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, scrub;
  logic [1:0] in_lbl, out_lbl, scrub_lbl;
  logic [7:0] in_data, out_data, drop_cnt;
  logic [1:0] occupancy;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_scrub;
  logic [1:0] b_in_lbl, b_out_lbl, b_scrub_lbl, b_drop_cnt, b_occupancy;
  logic [7:0] b_in_data, b_out_data;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  labeled_elastic_pipe u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_lbl(in_lbl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lbl(out_lbl), .out_data(out_data),
    .scrub(scrub), .scrub_lbl(scrub_lbl), .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  labeled_elastic_pipe #(.FLOOR(2'b10), .CW(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_lbl(b_in_lbl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_lbl(b_out_lbl), .out_data(b_out_data),
    .scrub(b_scrub), .scrub_lbl(b_scrub_lbl), .occupancy(b_occupancy), .drop_cnt(b_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; registered outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [7:0] stream_data [3];
  logic [7:0] bp_data [3];

  initial begin
    stream_data[0] = 8'h11; stream_data[1] = 8'h22; stream_data[2] = 8'h33;
    bp_data[0] = 8'hA1; bp_data[1] = 8'hA2; bp_data[2] = 8'hA3;

    rst = 1'b1; in_valid = 1'b0; in_lbl = '0; in_data = '0; out_ready = 1'b0;
    scrub = 1'b0; scrub_lbl = '0;
    b_in_valid = 1'b0; b_in_lbl = '0; b_in_data = '0; b_out_ready = 1'b0;
    b_scrub = 1'b0; b_scrub_lbl = '0;
    step();
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_occupancy", 32'(occupancy), 0);
    check("reset_drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;

    // Stream: back-to-back entries at full throughput
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        in_valid = 1'b1; in_lbl = 2'b01; in_data = stream_data[k];
        settle();
        check($sformatf("stream_in_ready_%0d", k), 32'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1 && k <= 3) begin
        check($sformatf("stream_valid_%0d", k), 32'(out_valid), 1);
        check($sformatf("stream_data_%0d", k), 32'(out_data), 32'(stream_data[k-1]));
        check($sformatf("stream_lbl_%0d", k), 32'(out_lbl), 1);
      end else begin
        check($sformatf("stream_valid_%0d", k), 32'(out_valid), 0);
      end
    end

    // Backpressure: third offer is refused while full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_lbl = 2'b01; in_data = bp_data[k];
      settle();
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), (k < 2) ? 1 : 0);
      step();
    end
    check("bp_occupancy_full", 32'(occupancy), 2);
    check("bp_head", 32'(out_data), 32'hA1);
    out_ready = 1'b1;
    settle();
    check("bp_release_in_ready", 32'(in_ready), 1);
    step();
    check("bp_occupancy_kept", 32'(occupancy), 2);
    check("bp_out_1", 32'(out_data), 32'hA2);
    in_valid = 1'b0;
    step();
    check("bp_out_2", 32'(out_data), 32'hA3);
    check("bp_out_2_valid", 32'(out_valid), 1);
    step();
    check("bp_empty", 32'(out_valid), 0);
    check("bp_empty_occ", 32'(occupancy), 0);

    // Bubble collapse: stalled head with an empty stage behind it
    out_ready = 1'b0;
    in_valid = 1'b1; in_lbl = 2'b01; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    step();
    check("bubble_occ", 32'(occupancy), 1);
    check("bubble_head", 32'(out_data), 32'h55);
    in_valid = 1'b1; in_data = 8'h66;
    settle();
    check("bubble_in_ready", 32'(in_ready), 1);
    step();
    check("bubble_occ_2", 32'(occupancy), 2);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bubble_out_2", 32'(out_data), 32'h66);
    step();
    check("bubble_empty", 32'(out_valid), 0);

    // Scrub removes the entry labelled 10 when survivors must flow to 01
    out_ready = 1'b0;
    in_valid = 1'b1; in_lbl = 2'b10; in_data = 8'h77;
    step();
    in_lbl = 2'b01; in_data = 8'h88;
    step();
    in_valid = 1'b0;
    scrub = 1'b1; scrub_lbl = 2'b01;
    settle();
    check("scrub_in_ready", 32'(in_ready), 0);
    check("scrub_out_valid", 32'(out_valid), 0);
    step();
    scrub = 1'b0;
    settle();
    check("scrub_s1_valid", 32'(out_valid), 0);
    check("scrub_s1_lbl", 32'(out_lbl), 0);
    check("scrub_s1_data", 32'(out_data), 0);
    check("scrub_drop_cnt", 32'(drop_cnt), 1);
    check("scrub_occ", 32'(occupancy), 1);
    out_ready = 1'b1;
    step();
    check("scrub_survivor", 32'(out_data), 32'h88);
    check("scrub_survivor_lbl", 32'(out_lbl), 1);
    step();
    check("scrub_drained", 32'(occupancy), 0);

    // Scrub with nothing offending only stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_lbl = 2'b01; in_data = 8'h90;
    step();
    in_data = 8'h91;
    step();
    in_valid = 1'b0; scrub = 1'b1; scrub_lbl = 2'b11;
    step();
    scrub = 1'b0;
    settle();
    check("noscrub_occ", 32'(occupancy), 2);
    check("noscrub_drop", 32'(drop_cnt), 1);
    check("noscrub_head", 32'(out_data), 32'h90);

    // Reset mid-stream discards without counting drops
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_data", 32'(out_data), 0);
    check("rst_mid_occ", 32'(occupancy), 0);
    check("rst_mid_drop", 32'(drop_cnt), 0);

    // Floor join on the second instance
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_lbl = 2'b01; b_in_data = 8'h3C;
    step();
    b_in_valid = 1'b0;
    step();
    check("floor_lbl", 32'(b_out_lbl), 3);
    check("floor_data", 32'(b_out_data), 32'h3C);
    step();

    // Saturating drop counter with CW=2: drop 2, then 2, then 1
    b_out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      b_in_valid = 1'b1; b_in_lbl = 2'b00; b_in_data = 8'(8'hC0 + r);
      step();
      if (r < 2) step();
      b_in_valid = 1'b0; b_scrub = 1'b1; b_scrub_lbl = 2'b01;
      step();
      b_scrub = 1'b0;
      settle();
      check($sformatf("sat_drop_%0d", r), 32'(b_drop_cnt), (r == 0) ? 2 : 3);
      check($sformatf("sat_occ_%0d", r), 32'(b_occupancy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/labeled_elastic_pipe.md
Name: labeled_elastic_pipe

Overview:
- Parametrised successor to the two-stage label/data propagation register chain.
- Carries a security label and a label-dependent data word through DEPTH elastic stages, with valid/ready backpressure and bubble collapsing.
- Adds a scrub operation that purges entries whose label does not flow to a given label, for domain switches.
- Sits between a labeled producer and consumer wherever data must be pipelined without losing or widening its label association.

Parameters:
- DEPTH, 2, number of register stages (>=1).
- DW, 8, data width.
- LW, 2, label width; lattice: join = bitwise OR, a flows-to b iff (a & ~b) == 0.
- FLOOR, 0, LW-bit label joined into every accepted label.
- CW, 8, drop counter width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has an entry.
- in_ready  out  1  pipe accepts an entry this cycle.
- in_lbl  in  LW  label of in_data.
- in_data  in  DW  data, labelled by in_lbl.
- out_valid  out  1  last stage holds an entry.
- out_ready  in  1  consumer takes the entry.
- out_lbl  out  LW  label of out_data.
- out_data  out  DW  data, labelled by out_lbl.
- scrub  in  1  purge request, one cycle.
- scrub_lbl  in  LW  label that surviving entries must flow to.
- occupancy  out  clog2(DEPTH+1)  count of valid stages.
- drop_cnt  out  CW  saturating count of scrubbed entries.

Behaviour:
- State per stage i (0 = input side, DEPTH-1 = output): v[i], lbl[i], data[i].
- Invariant: v[i]=0 implies lbl[i]=0 and data[i]=0. No residue is allowed in empty stages.
- Reset: all v, lbl, data = 0 and drop_cnt = 0. Hence out_valid=0, out_lbl=0, out_data=0, occupancy=0. Reset mid-stream discards all entries without counting them as drops. Reset has priority over scrub and over transfers.
- Outputs out_valid/out_lbl/out_data are driven directly from stage DEPTH-1 (registered).
- Advance chain, normal cycle (scrub=0):
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - adv[i] = adv[i+1] | ~v[i].
  - in_ready = adv[0]. This is combinational from out_ready, so the pipe reaches full throughput with no bubbles.
- Stage load on adv[i]:
  - Stage i loads the predecessor's v/lbl/data; stage 0 loads from the input.
  - If the source is invalid, the stage becomes v=0, lbl=0, data=0.
  - Where adv[i]=0, the stage holds.
- Input accept (in_valid & in_ready): stage 0 gets v=1, lbl = in_lbl | FLOOR, data = in_data.
- Latency: an entry accepted in cycle t appears at the outputs in cycle t+DEPTH if not stalled. Throughput is 1 per cycle.
- Order is always preserved; entries are never duplicated.
- Scrub cycle (scrub=1):
  - in_ready=0 and out_valid=0 (forced); no shift, no transfer.
  - Next state: every stage with v=1 and lbl not flowing to scrub_lbl is cleared (v=0, lbl=0, data=0). All other stages hold.
  - drop_cnt += number cleared, saturating at 2^CW-1.
  - Survivors keep their positions; any gaps collapse over following normal cycles.
- A scrub with no offending entries changes nothing except costing one stalled cycle.
- occupancy = popcount of v[] (registered source, combinational count).
- Full: all v=1 and out_ready=0 -> in_ready=0.
- Empty: out_valid=0; an accepted input reaches the outputs after DEPTH cycles.
- Simultaneous accept and output transfer while full: allowed, occupancy unchanged.
- in_lbl/in_data are ignored while in_valid=0 or in_ready=0.

Test Plan (DEPTH=2, DW=8, LW=2 unless noted):
- Stream: rst for 1 cycle; in_data 0x11/0x22/0x33 with lbl 01 on back-to-back cycles, out_ready=1 -> out_valid from cycle 2 for 3 cycles, data 0x11,0x22,0x33, out_lbl=01, in_ready constantly 1.
- Backpressure: out_ready=0; offer 0xA1,0xA2,0xA3 -> first two accepted, in_ready=0 on the third, occupancy=2. Raise out_ready -> 0xA1,0xA2,0xA3 emerge in order, none lost or duplicated.
- Bubble collapse: stage1 holds 0x55 stalled with stage0 empty; offer 0x66 -> in_ready=1 and stage0 gets 0x66. Release -> 0x55 then 0x66.
- Scrub: stage1 holds (lbl 10, 0x77), stage0 holds (lbl 01, 0x88); scrub=1, scrub_lbl=01 -> during that cycle in_ready=0 and out_valid=0. Next cycle: stage1 v=0, lbl=0, data=0; drop_cnt=1; occupancy=1; 0x88 exits one cycle later.
- Floor join: FLOOR=2'b10, in_lbl=01, data 0x3C -> out_lbl=11, out_data=0x3C.
- Reset/saturation: full pipe, assert rst -> next cycle out_valid=0, out_data=0, occupancy=0, drop_cnt=0. With CW=2, drop 5 entries via scrubs -> drop_cnt=3 and held.
